rom_sdram_writer: RTL

Consumes the ROM byte stream from the system SPI block (`rom_loading`, `rom_do`, `rom_do_valid`) and writes it into SDRAM as 16-bit little-endian words through a req/ack write port. A small word FIFO absorbs SDRAM latency. The first header bytes are mirrored to a header port for mapper detection, and the final ROM size is reported. It sits between the system block and the SDRAM controller's loader port.

---
 rtl/tangcore_pkg.sv | 18 +
 rtl/sync_fifo.sv | 59 +++++
 rtl/rom_sdram_writer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tangcore_pkg.sv
// Shared state encodings and defaults for the ROM loader path.
package tangcore_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } top_state_e;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_REQ  = 1'b1
  } wr_state_e;

  localparam int HEADER_BYTES_DEF = 64;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty flags; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == (AW+1)'(0));
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_dout    = r_mem[r_rd_ptr];

  // pointer and occupancy bookkeeping
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= AW'(0);
      r_rd_ptr <= AW'(0);
      r_count  <= (AW+1)'(0);
    end else if (i_clr) begin
      r_wr_ptr <= AW'(0);
      r_rd_ptr <= AW'(0);
      r_count  <= (AW+1)'(0);
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // storage array, no reset needed on the data path
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/rom_sdram_writer.sv
// Packs the SPI ROM byte stream into 16-bit little-endian words and writes them
// to SDRAM through a req/ack port, buffered by a small word FIFO.
module rom_sdram_writer
  import tangcore_pkg::*;
#(
  parameter int ADDR_W       = 22,
  parameter int FIFO_DEPTH   = 8,
  parameter int HEADER_BYTES = HEADER_BYTES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rom_loading,
  input  logic [7:0]        rom_do,
  input  logic              rom_do_valid,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_din,
  input  logic              mem_ack,
  output logic              hdr_we,
  output logic [5:0]        hdr_addr,
  output logic [7:0]        hdr_data,
  output logic [23:0]       rom_size,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  top_state_e        r_state, w_state_nxt;
  wr_state_e         r_wstate, w_wstate_nxt;

  logic              r_loading_q;
  logic              r_start_pend;
  logic              r_phase;
  logic [7:0]        r_lo_byte;
  logic [23:0]       r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_din;
  logic              r_mem_req;
  logic              r_hdr_we;
  logic [5:0]        r_hdr_addr;
  logic [7:0]        r_hdr_data;
  logic              r_overflow;
  logic              r_busy;
  logic              r_done;

  logic              w_rise;
  logic              w_start;
  logic              w_accept;
  logic              w_push;
  logic [15:0]       w_push_data;
  logic              w_pop;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [15:0]       w_fifo_dout;
  logic              w_ack_ok;
  logic              w_drop;
  logic              w_wrap;

  assign w_rise   = rom_loading && !r_loading_q;
  assign w_accept = (r_state == LOAD) && rom_do_valid;
  assign w_pop    = (r_wstate == W_IDLE) && !w_fifo_empty;
  assign w_ack_ok = (r_wstate == W_REQ) && mem_ack;
  assign w_drop   = w_push && w_fifo_full && !w_pop;
  assign w_wrap   = w_ack_ok && (r_addr == {ADDR_W{1'b1}});

  assign mem_req  = r_mem_req;
  assign mem_addr = r_addr;
  assign mem_din  = r_din;
  assign hdr_we   = r_hdr_we;
  assign hdr_addr = r_hdr_addr;
  assign hdr_data = r_hdr_data;
  assign rom_size = r_size;
  assign busy     = r_busy;
  assign done     = r_done;
  assign overflow = r_overflow;

  // top FSM next state; a load (re)starts from IDLE or directly out of DONE
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise || r_start_pend) begin
          w_state_nxt = LOAD;
          w_start     = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      LOAD: begin
        // level test also covers a latched start whose rom_loading already fell
        if (!rom_loading) begin
          w_state_nxt = FLUSH;
        end else begin
          w_state_nxt = LOAD;
        end
      end
      FLUSH: begin
        if (!r_phase && w_fifo_empty && (r_wstate == W_IDLE)) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = FLUSH;
        end
      end
      DONE: begin
        if (w_rise || r_start_pend) begin
          w_state_nxt = LOAD;
          w_start     = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // word assembly: odd bytes complete a word, a pending even byte is padded in FLUSH
  always_comb begin
    w_push      = 1'b0;
    w_push_data = 16'h0000;
    if (w_accept && r_phase) begin
      w_push      = 1'b1;
      w_push_data = {rom_do, r_lo_byte};
    end else if ((r_state == FLUSH) && r_phase) begin
      w_push      = 1'b1;
      w_push_data = {8'h00, r_lo_byte};
    end else begin
      w_push      = 1'b0;
      w_push_data = 16'h0000;
    end
  end

  // writer sub-FSM next state
  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE: begin
        if (!w_fifo_empty) begin
          w_wstate_nxt = W_REQ;
        end else begin
          w_wstate_nxt = W_IDLE;
        end
      end
      W_REQ: begin
        if (mem_ack) begin
          w_wstate_nxt = W_IDLE;
        end else begin
          w_wstate_nxt = W_REQ;
        end
      end
      default: begin
        w_wstate_nxt = W_IDLE;
      end
    endcase
  end

  // state registers, edge detector and registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_wstate     <= W_IDLE;
      r_loading_q  <= 1'b0;
      r_start_pend <= 1'b0;
      r_mem_req    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wstate    <= w_wstate_nxt;
      r_loading_q <= rom_loading;
      r_mem_req   <= (w_wstate_nxt == W_REQ);
      r_busy      <= (w_state_nxt != IDLE);
      r_done      <= (w_state_nxt == DONE);
      if (w_start) begin
        r_start_pend <= 1'b0;
      end else if (w_rise && ((r_state == FLUSH) || (r_state == DONE))) begin
        r_start_pend <= 1'b1;
      end else begin
        r_start_pend <= r_start_pend;
      end
    end
  end

  // byte phase, size counter and header mirror
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase    <= 1'b0;
      r_lo_byte  <= 8'h00;
      r_size     <= 24'd0;
      r_hdr_we   <= 1'b0;
      r_hdr_addr <= 6'd0;
      r_hdr_data <= 8'h00;
    end else begin
      r_hdr_we <= w_accept && (r_size < 24'(HEADER_BYTES));
      if (w_accept) begin
        r_hdr_addr <= r_size[5:0];
        r_hdr_data <= rom_do;
      end
      if (w_start) begin
        r_phase <= 1'b0;
        r_size  <= 24'd0;
      end else if (w_accept) begin
        r_phase <= !r_phase;
        if (!r_phase) r_lo_byte <= rom_do;
        if (r_size != 24'hFFFFFF) r_size <= r_size + 24'd1;
      end else if (r_state == FLUSH) begin
        r_phase <= 1'b0;
      end
    end
  end

  // SDRAM write port: data captured on pop, address advances on ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_din      <= 16'h0000;
      r_addr     <= {ADDR_W{1'b0}};
      r_overflow <= 1'b0;
    end else begin
      if (w_pop) r_din <= w_fifo_dout;
      if (w_start) begin
        r_addr <= {ADDR_W{1'b0}};
      end else if (w_ack_ok) begin
        r_addr <= r_addr + ADDR_W'(1);
      end
      if (w_start) begin
        r_overflow <= 1'b0;
      end else if (w_drop || w_wrap) begin
        r_overflow <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_clr   (w_start),
    .i_push  (w_push),
    .i_din   (w_push_data),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

endmodule
